// File: rtl/encoder_8to3.sv
// encoder_8to3 - registered 8-to-3 priority encoder with enable.
//
// Compacts an 8-bit request vector into the 3-bit index of its highest set
// bit. Multi-hot inputs resolve to the highest index. All outputs are
// registered, so the latency is 1 cycle, and they clear asynchronously on reset.
//
// Parameters:
//   HOLD_ON_DISABLE  0: y is cleared while en is low
//                    1: y keeps its last value while en is low
//                    In both cases valid is cleared while en is low.
//
// Optional feature (macro ENCODER_ONEHOT_CHECK_EN):
//   When defined, the design adds a registered err output. err is 1 when an
//   enabled request has more than one bit set.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   i      in   [7:0] request vector; bit k is request k
//   en     in   encode enable, active high
//   y      out  [2:0] index of the highest set bit of i (registered)
//   err    out  multi-hot flag (only with ENCODER_ONEHOT_CHECK_EN)
//   valid  out  y reflects an enabled, non-zero request (registered)
module encoder_8to3 #(
  parameter bit HOLD_ON_DISABLE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i,
  input  logic       en,
  output logic [2:0] y,
`ifdef ENCODER_ONEHOT_CHECK_EN
  output logic       err,
`endif
  output logic       valid
);

  logic [2:0] idx;
  logic       any_req;

  // Ascending scan: a later (higher) set bit overwrites an earlier one, so the
  // highest set bit wins.
  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (i[k]) idx = 3'(k);
    end
  end

  assign any_req = |i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 3'd0;
      valid <= 1'b0;
    end else begin
      valid <= en & any_req;
      if (en)                   y <= idx;  // i == 0 gives idx 0, so y reads 000
      else if (!HOLD_ON_DISABLE) y <= 3'd0;
    end
  end

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic multi_hot;

  // Clearing the lowest set bit leaves a non-zero value only when two or
  // more bits were set.
  assign multi_hot = |(i & (i - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= en & multi_hot;
  end
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i;
  logic       en;
  logic [2:0] y0, y1;
  logic       valid0, valid1;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic       err0, err1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Two instances that share stimulus: one clears y on disable, one holds it.
  encoder_8to3 #(.HOLD_ON_DISABLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en), .y(y0),
`ifdef ENCODER_ONEHOT_CHECK_EN
    .err(err0),
`endif
    .valid(valid0));

  encoder_8to3 #(.HOLD_ON_DISABLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i), .en(en), .y(y1),
`ifdef ENCODER_ONEHOT_CHECK_EN
    .err(err1),
`endif
    .valid(valid1));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] i;
    logic [2:0] y0;  // expected y with HOLD_ON_DISABLE=0
    logic [2:0] y1;  // expected y with HOLD_ON_DISABLE=1
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Applies one vector on a falling edge, queues its hand-computed response,
  // and returns on the next falling edge (after the capture edge).
  task automatic drive(input logic [7:0] vi, input logic ve, input logic [2:0] ey0,
                       input logic [2:0] ey1, input logic ev, input logic ee);
    exp_t x;
    i = vi;
    en = ve;
    x.i = vi; x.y0 = ey0; x.y1 = ey1; x.v = ev; x.e = ee;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " y0"}, {5'd0, y0}, 8'd0);
    chk({nm, " y1"}, {5'd0, y1}, 8'd0);
    chk({nm, " valid0"}, {7'd0, valid0}, 8'd0);
    chk({nm, " valid1"}, {7'd0, valid1}, 8'd0);
`ifdef ENCODER_ONEHOT_CHECK_EN
    chk({nm, " err0"}, {7'd0, err0}, 8'd0);
    chk({nm, " err1"}, {7'd0, err1}, 8'd0);
`endif
  endtask

  // Monitor: one result per capture edge; compare whenever a response is owed.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk($sformatf("y hold0 i=%h", x.i), {5'd0, y0}, {5'd0, x.y0});
        chk($sformatf("y hold1 i=%h", x.i), {5'd0, y1}, {5'd0, x.y1});
        chk($sformatf("valid0 i=%h", x.i), {7'd0, valid0}, {7'd0, x.v});
        chk($sformatf("valid1 i=%h", x.i), {7'd0, valid1}, {7'd0, x.v});
`ifdef ENCODER_ONEHOT_CHECK_EN
        chk($sformatf("err0 i=%h", x.i), {7'd0, err0}, {7'd0, x.e});
        chk($sformatf("err1 i=%h", x.i), {7'd0, err1}, {7'd0, x.e});
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    i     = 8'h00;

    // Reset with an active request and no clock edge: outputs clear at once.
    @(negedge clk);
    i = 8'hFF; en = 1'b1; rst_n = 1'b0;
    #1;
    chk_cleared("async reset");
    @(negedge clk);
    chk_cleared("held in reset");

    // Release; the first edge captures FF.
    rst_n = 1'b1;
    drive(8'hFF, 1, 3'd7, 3'd7, 1, 1);

    // One-hot sweep.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << k;
      drive(oh, 1, 3'(k), 3'(k), 1, 0);
    end

    // Priority on multi-hot inputs.
    drive(8'h81, 1, 3'd7, 3'd7, 1, 1);
    drive(8'h16, 1, 3'd4, 3'd4, 1, 1);

    // Zero input versus index 0.
    drive(8'h00, 1, 3'd0, 3'd0, 0, 0);
    drive(8'h01, 1, 3'd0, 3'd0, 1, 0);

    // Disable: clear versus hold; i is ignored while disabled.
    drive(8'h40, 1, 3'd6, 3'd6, 1, 0);
    drive(8'h40, 0, 3'd0, 3'd6, 0, 0);
    drive(8'hFF, 0, 3'd0, 3'd6, 0, 0);
    drive(8'h03, 0, 3'd0, 3'd6, 0, 0);
    drive(8'h03, 1, 3'd1, 3'd1, 1, 1);

    // Reset between edges with a non-zero result on the outputs.
    drive(8'h20, 1, 3'd5, 3'd5, 1, 0);
    rst_n = 1'b0;
    #1;
    chk_cleared("mid-stream reset");
    @(negedge clk);
    rst_n = 1'b1;

    // The held value after reset is the reset value; the pending request is lost.
    drive(8'h80, 0, 3'd0, 3'd0, 0, 0);
    drive(8'h0C, 1, 3'd3, 3'd3, 1, 1);

    // Bounded drain of any outstanding responses.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
